// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, memory controls, IF/ID register, program load
// Optional FETCH_PERF_COUNTER_EN adds fetchCount/stallCount outputs.
module fetch_stage #(
  parameter int WIDTH = 32,
  parameter int ADDR_BITS = 4,
  parameter logic [ADDR_BITS-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 loadMode,
  input  logic                 loadValid,
  input  logic [ADDR_BITS-1:0] loadAddress,
  input  logic [WIDTH-1:0]     loadData,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 branchTaken,
  input  logic [ADDR_BITS-1:0] branchTarget,
  output logic [WIDTH-1:0]     instructionAddress,
  output logic                 writeEnable,
  output logic                 fetchEnable,
  output logic [WIDTH-1:0]     instructionInput,
  input  logic [WIDTH-1:0]     instructionOutput,
  output logic [WIDTH-1:0]     ifIdInstruction,
  output logic [ADDR_BITS-1:0] ifIdPc,
  output logic                 ifIdValid,
  output logic                 halted
`ifdef FETCH_PERF_COUNTER_EN
  ,
  output logic [31:0]          fetchCount,
  output logic [31:0]          stallCount
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} stateT;

  stateT state, nextState;
  logic [ADDR_BITS-1:0] pc;
  logic startRun, haltHit, redirect, advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState   = state;
    writeEnable = 1'b0;
    fetchEnable = 1'b0;
    startRun    = 1'b0;
    haltHit     = 1'b0;
    redirect    = 1'b0;
    advance     = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (loadMode) begin
          nextState = LOAD;
        end else if (start) begin
          nextState = RUN;
          startRun  = 1'b1;
        end
      end
      LOAD: begin
        writeEnable = loadValid;
        if (!loadMode) nextState = IDLE;
      end
      RUN: begin
        fetchEnable = !stall;
        // A live halt word stops fetch; whatever is being fetched this cycle is wrong-path.
        if (ifIdValid && (instructionOutput == HALT_WORD) && !flush) begin
          haltHit   = 1'b1;
          nextState = HALT;
        end else if (branchTaken) begin
          redirect = 1'b1;
        end else if (!stall) begin
          advance = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      ifIdPc    <= '0;
      ifIdValid <= 1'b0;
    end else begin
      if (startRun)      pc <= RESET_PC;
      else if (redirect) pc <= branchTarget;
      else if (advance)  pc <= pc + 1'b1;

      if (advance) ifIdPc <= pc;

      if ((state != RUN) || haltHit || redirect || flush) ifIdValid <= 1'b0;
      else if (advance)                                   ifIdValid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_COUNTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchCount <= '0;
      stallCount <= '0;
    end else if (startRun) begin
      fetchCount <= '0;
      stallCount <= '0;
    end else begin
      if (advance && !flush && (fetchCount != 32'hFFFFFFFF))
        fetchCount <= fetchCount + 32'd1;
      if ((state == RUN) && stall && (stallCount != 32'hFFFFFFFF))
        stallCount <= stallCount + 32'd1;
    end
  end
`endif

  assign instructionAddress = {{(WIDTH-ADDR_BITS){1'b0}}, (state == LOAD) ? loadAddress : pc};
  assign instructionInput   = loadData;
  assign ifIdInstruction    = instructionOutput;
  assign halted             = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a registered instruction memory model
module tb_fetch_stage;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 0, loadMode = 0, loadValid = 0, stall = 0, flush = 0, branchTaken = 0;
  logic [3:0]  loadAddress = '0, branchTarget = '0;
  logic [31:0] loadData = '0;
  logic [31:0] instructionAddress, instructionInput, ifIdInstruction;
  logic [31:0] instructionOutput = '0;
  logic        writeEnable, fetchEnable, ifIdValid, halted;
  logic [3:0]  ifIdPc;

  logic [31:0] mem [16];
  logic [31:0] golden [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loadMode(loadMode), .loadValid(loadValid),
    .loadAddress(loadAddress), .loadData(loadData), .stall(stall), .flush(flush),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .instructionAddress(instructionAddress), .writeEnable(writeEnable), .fetchEnable(fetchEnable),
    .instructionInput(instructionInput), .instructionOutput(instructionOutput),
    .ifIdInstruction(ifIdInstruction), .ifIdPc(ifIdPc), .ifIdValid(ifIdValid), .halted(halted)
  );

  // Synchronous-write, registered-read instruction memory
  always @(posedge clk) begin
    if (writeEnable) mem[instructionAddress[3:0]] <= instructionInput;
    if (fetchEnable) instructionOutput <= mem[instructionAddress[3:0]];
  end

  typedef struct {
    logic       st, fl, br;
    logic [3:0] tgt;
    logic       expFe, expValid;
    logic [3:0] expPc;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic s, input logic f, input logic b, input logic [3:0] t,
                              input logic fe, input logic v, input logic [3:0] p);
    vec_t r;
    r.st = s; r.fl = f; r.br = b; r.tgt = t; r.expFe = fe; r.expValid = v; r.expPc = p;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadRange(input int first, input int count);
    loadMode = 1; loadValid = 0;
    tick();
    for (int i = first; i < first + count; i++) begin
      loadValid = 1; loadAddress = 4'(i); loadData = golden[i];
      #1;
      chk("load_we", {31'b0, writeEnable}, 32'd1);
      chk("load_addr", instructionAddress, 32'(i));
      tick();
    end
    loadValid = 0; loadMode = 0;
    tick();
    chk("load_exit_halted", {31'b0, halted}, 32'd0);
  endtask

  task automatic pulseStart();
    start = 1;
    tick();
    start = 0;
    chk("start_valid", {31'b0, ifIdValid}, 32'd0);
    chk("start_halted", {31'b0, halted}, 32'd0);
  endtask

  task automatic expectIfId(input string nm, input logic [3:0] p, input logic [31:0] ins);
    chk({nm, "_valid"}, {31'b0, ifIdValid}, 32'd1);
    chk({nm, "_pc"}, {28'b0, ifIdPc}, {28'b0, p});
    chk({nm, "_instr"}, ifIdInstruction, ins);
  endtask

  task automatic checkResetOutputs(input string nm);
    chk({nm, "_we"}, {31'b0, writeEnable}, 32'd0);
    chk({nm, "_fe"}, {31'b0, fetchEnable}, 32'd0);
    chk({nm, "_valid"}, {31'b0, ifIdValid}, 32'd0);
    chk({nm, "_pc"}, {28'b0, ifIdPc}, 32'd0);
    chk({nm, "_halted"}, {31'b0, halted}, 32'd0);
    chk({nm, "_addr"}, instructionAddress, 32'd0);
  endtask

  initial begin
    int mpc, mvpc;
    bit mvalid;
    logic s, f, b;
    logic [3:0] t;

    tbl[0]  = mk(0, 0, 0, 0,  1, 1, 0);
    tbl[1]  = mk(0, 0, 0, 0,  1, 1, 1);
    tbl[2]  = mk(1, 0, 0, 0,  0, 1, 1);
    tbl[3]  = mk(1, 0, 0, 0,  0, 1, 1);
    tbl[4]  = mk(1, 0, 0, 0,  0, 1, 1);
    tbl[5]  = mk(0, 0, 0, 0,  1, 1, 2);
    tbl[6]  = mk(0, 0, 1, 9,  1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0,  1, 1, 9);
    tbl[8]  = mk(1, 1, 1, 14, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0,  1, 1, 14);
    tbl[10] = mk(0, 0, 0, 0,  1, 1, 15);
    tbl[11] = mk(0, 0, 0, 0,  1, 1, 0);
    tbl[12] = mk(0, 1, 0, 0,  1, 0, 0);
    tbl[13] = mk(0, 0, 0, 0,  1, 1, 2);
    tbl[14] = mk(1, 1, 0, 0,  0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0,  1, 1, 3);

    for (int i = 0; i < 16; i++) mem[i] = '0;

    tick(); tick();
    checkResetOutputs("reset");
    rst_n = 1;
    tick();

    // Table: distinct words, stall/branch/flush/wrap patterns
    for (int i = 0; i < 16; i++) golden[i] = 32'h100 + 32'(i);
    loadRange(0, 16);
    pulseStart();
    for (int i = 0; i < 16; i++) begin
      stall = tbl[i].st; flush = tbl[i].fl; branchTaken = tbl[i].br; branchTarget = tbl[i].tgt;
      #1;
      chk($sformatf("vec%0d_fe", i), {31'b0, fetchEnable}, {31'b0, tbl[i].expFe});
      tick();
      chk($sformatf("vec%0d_valid", i), {31'b0, ifIdValid}, {31'b0, tbl[i].expValid});
      if (tbl[i].expValid) begin
        chk($sformatf("vec%0d_pc", i), {28'b0, ifIdPc}, {28'b0, tbl[i].expPc});
        chk($sformatf("vec%0d_instr", i), ifIdInstruction, 32'h100 + {28'b0, tbl[i].expPc});
      end
    end
    stall = 0; flush = 0; branchTaken = 0;

    // Asynchronous reset in the middle of RUN
    tick();
    #2 rst_n = 0;
    #1 checkResetOutputs("rst_run");
    tick();
    rst_n = 1;

    // Halt program, run straight through
    golden[0] = 32'h11; golden[1] = 32'h22; golden[2] = 32'h33; golden[3] = HALT;
    loadRange(0, 4);
    pulseStart();
    tick(); expectIfId("h0", 0, 32'h11);
    tick(); expectIfId("h1", 1, 32'h22);
    tick(); expectIfId("h2", 2, 32'h33);
    tick(); expectIfId("h3", 3, HALT);
    chk("h3_fe", {31'b0, fetchEnable}, 32'd1);
    tick();
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_valid", {31'b0, ifIdValid}, 32'd0);
    chk("halt_fe", {31'b0, fetchEnable}, 32'd0);
    tick();
    chk("halt_stays", {31'b0, halted}, 32'd1);

    // Restart from HALT with a 3-cycle stall after the second word
    pulseStart();
    tick(); expectIfId("s0", 0, 32'h11);
    tick(); expectIfId("s1", 1, 32'h22);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_fe", {31'b0, fetchEnable}, 32'd0);
      tick(); expectIfId("stall_hold", 1, 32'h22);
    end
    stall = 0;
    tick(); expectIfId("s2", 2, 32'h33);
    tick(); expectIfId("s3", 3, HALT);
    tick();
    chk("s_halted", {31'b0, halted}, 32'd1);

    // Asynchronous reset in the middle of LOAD, from HALT
    loadMode = 1;
    tick();
    loadValid = 1; loadAddress = 4'd5; loadData = 32'hABCD;
    #1 chk("midload_we", {31'b0, writeEnable}, 32'd1);
    #1 rst_n = 0;
    #1 checkResetOutputs("rst_load");
    loadMode = 0; loadValid = 0;
    tick();
    rst_n = 1;
    tick();

    // Randomized run against a program-order reference model
    for (int i = 0; i < 16; i++) begin
      golden[i] = $urandom;
      if (golden[i] == HALT) golden[i] = 32'h0;
    end
    loadRange(0, 16);
    pulseStart();
    mpc = 0; mvalid = 0; mvpc = 0;
    for (int c = 0; c < 400; c++) begin
      s = ($urandom_range(0, 9) < 3);
      f = ($urandom_range(0, 9) < 1);
      b = ($urandom_range(0, 9) < 1);
      t = 4'($urandom_range(0, 15));
      stall = s; flush = f; branchTaken = b; branchTarget = t;
      #1;
      chk("rnd_fe", {31'b0, fetchEnable}, {31'b0, !s});
      chk("rnd_addr", instructionAddress, 32'(mpc));
      tick();
      if (b) begin
        mvalid = 0;
        mpc = int'(t);
      end else if (s) begin
        if (f) mvalid = 0;
      end else begin
        mvpc = mpc;
        mvalid = !f;
        mpc = (mpc + 1) % 16;
      end
      chk("rnd_valid", {31'b0, ifIdValid}, {31'b0, mvalid});
      if (mvalid) begin
        chk("rnd_pc", {28'b0, ifIdPc}, 32'(mvpc));
        chk("rnd_instr", ifIdInstruction, golden[mvpc]);
      end
    end
    stall = 0; flush = 0; branchTaken = 0;
    chk("rnd_not_halted", {31'b0, halted}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
